// File: rtl/lvds_rx_frame_align.sv
// rtl/lvds_rx_frame_align.sv - frame-clock word alignment FSM for a 9-channel x6 LVDS deserializer
//
// Purpose: watches the deserialized frame-clock channel (rx_data[53:48]) and
// pulses rx_data_align until it equals FRAME_PATTERN, then declares lock,
// forwards the 48 data bits with a valid flag, counts frame errors while
// locked, and returns to alignment after LOSS_COUNT consecutive mismatches.
//
// Ports:
//   rx_clk        in   deserializer rx_outclock, all logic on rising edge
//   reset_n       in   asynchronous active-low reset (released synchronously)
//   rx_locked     in   deserializer PLL lock
//   rx_data       in   54-bit deserializer word, channel c at [6c+5:6c]
//   rx_data_align out  registered slip request to the deserializer
//   data_out      out  rx_data[47:0] delayed by one cycle
//   data_valid    out  data_out came from a locked, pattern-matching frame
//   align_locked  out  high while in LOCKED
//   slip_cnt      out  slips since last entry to CHECK_ALIGN from IDLE (0..5)
//   align_fail    out  sticky, set when six slips pass without a lock
//   err_cnt       out  saturating count of mismatching frames while locked

module lvds_rx_frame_align #(
  parameter logic [5:0] FRAME_PATTERN = 6'b111000,
  parameter int         MATCH_COUNT   = 16,
  parameter int         ALIGN_PULSE   = 2,
  parameter int         HOLDOFF       = 4,
  parameter int         LOSS_COUNT    = 4
) (
  input  logic        rx_clk,
  input  logic        reset_n,
  input  logic        rx_locked,
  input  logic [53:0] rx_data,
  output logic        rx_data_align,
  output logic [47:0] data_out,
  output logic        data_valid,
  output logic        align_locked,
  output logic [2:0]  slip_cnt,
  output logic        align_fail,
  output logic [15:0] err_cnt
);

  localparam int PW = (ALIGN_PULSE > 1) ? $clog2(ALIGN_PULSE) : 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int LW = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SLIP,
    S_HOLD,
    S_LOCKED
  } state_t;

  state_t        state, state_n;
  logic [7:0]    match_cnt, match_cnt_n;
  logic [PW-1:0] pulse_cnt, pulse_cnt_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [LW-1:0] loss_cnt, loss_cnt_n;
  logic [2:0]    slip_cnt_n;
  logic          align_fail_n;
  logic [15:0]   err_cnt_n;
  logic          match;

  // Reset asserts immediately but releases two edges later, so no flop sees
  // reset_n deassert close to an rx_clk edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  assign match        = (rx_data[53:48] == FRAME_PATTERN);
  assign align_locked = (state == S_LOCKED);

  always_comb begin
    state_n      = state;
    match_cnt_n  = match_cnt;
    pulse_cnt_n  = pulse_cnt;
    hold_cnt_n   = hold_cnt;
    loss_cnt_n   = loss_cnt;
    slip_cnt_n   = slip_cnt;
    align_fail_n = align_fail;
    err_cnt_n    = err_cnt;

    if (!rx_locked) begin
      // Loss of PLL lock overrides everything; history counters are kept.
      state_n     = S_IDLE;
      match_cnt_n = '0;
      pulse_cnt_n = '0;
      hold_cnt_n  = '0;
      loss_cnt_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n     = S_CHECK;
          match_cnt_n = '0;
          slip_cnt_n  = '0;
        end
        S_CHECK: begin
          if (match) begin
            if (match_cnt == 8'(MATCH_COUNT - 1)) begin
              state_n     = S_LOCKED;
              match_cnt_n = '0;
              loss_cnt_n  = '0;
            end else begin
              match_cnt_n = match_cnt + 8'd1;
            end
          end else begin
            state_n     = S_SLIP;
            match_cnt_n = '0;
            pulse_cnt_n = '0;
            // Six slips cover every rotation of a 6-bit word; a seventh
            // attempt means the pattern cannot be found, but keep trying.
            if (slip_cnt == 3'd5) begin
              slip_cnt_n   = '0;
              align_fail_n = 1'b1;
            end else begin
              slip_cnt_n = slip_cnt + 3'd1;
            end
          end
        end
        S_SLIP: begin
          if (pulse_cnt == PW'(ALIGN_PULSE - 1)) begin
            state_n    = S_HOLD;
            hold_cnt_n = '0;
          end else begin
            pulse_cnt_n = pulse_cnt + PW'(1);
          end
        end
        S_HOLD: begin
          // Let the deserializer settle after a slip before judging the word.
          if (hold_cnt == HW'(HOLDOFF - 1)) begin
            state_n     = S_CHECK;
            match_cnt_n = '0;
          end else begin
            hold_cnt_n = hold_cnt + HW'(1);
          end
        end
        S_LOCKED: begin
          if (match) begin
            loss_cnt_n = '0;
          end else begin
            if (err_cnt != 16'hFFFF) err_cnt_n = err_cnt + 16'd1;
            if (loss_cnt == LW'(LOSS_COUNT - 1)) begin
              state_n     = S_CHECK;
              match_cnt_n = '0;
              loss_cnt_n  = '0;
            end else begin
              loss_cnt_n = loss_cnt + LW'(1);
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state         <= S_IDLE;
      match_cnt     <= '0;
      pulse_cnt     <= '0;
      hold_cnt      <= '0;
      loss_cnt      <= '0;
      slip_cnt      <= '0;
      align_fail    <= 1'b0;
      err_cnt       <= '0;
      rx_data_align <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
    end else begin
      state         <= state_n;
      match_cnt     <= match_cnt_n;
      pulse_cnt     <= pulse_cnt_n;
      hold_cnt      <= hold_cnt_n;
      loss_cnt      <= loss_cnt_n;
      slip_cnt      <= slip_cnt_n;
      align_fail    <= align_fail_n;
      err_cnt       <= err_cnt_n;
      // Driven straight from a flop so the deserializer never sees a glitch.
      rx_data_align <= (state_n == S_SLIP);
      data_out      <= rx_data[47:0];
      data_valid    <= (state == S_LOCKED) && match;
    end
  end

endmodule

// File: tb/tb_lvds_rx_frame_align.sv
// tb/tb_lvds_rx_frame_align.sv - self-checking bench for lvds_rx_frame_align

module tb_lvds_rx_frame_align;

  localparam logic [5:0] PAT = 6'b111000;
  localparam logic [5:0] BAD = 6'b000111;

  logic        rx_clk;
  logic        reset_n;
  logic        rx_locked;
  logic [53:0] rx_data;

  logic        rx_data_align, data_valid, align_locked, align_fail;
  logic [47:0] data_out;
  logic [2:0]  slip_cnt;
  logic [15:0] err_cnt;

  logic        rx_data_align2, data_valid2, align_locked2, align_fail2;
  logic [47:0] data_out2;
  logic [2:0]  slip_cnt2;
  logic [15:0] err_cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [47:0] sb_q[$];

  lvds_rx_frame_align dut (
    .rx_clk(rx_clk), .reset_n(reset_n), .rx_locked(rx_locked), .rx_data(rx_data),
    .rx_data_align(rx_data_align), .data_out(data_out), .data_valid(data_valid),
    .align_locked(align_locked), .slip_cnt(slip_cnt), .align_fail(align_fail),
    .err_cnt(err_cnt)
  );

  // Large loss threshold keeps this copy locked through a long error burst.
  lvds_rx_frame_align #(.LOSS_COUNT(70000)) dut2 (
    .rx_clk(rx_clk), .reset_n(reset_n), .rx_locked(rx_locked), .rx_data(rx_data),
    .rx_data_align(rx_data_align2), .data_out(data_out2), .data_valid(data_valid2),
    .align_locked(align_locked2), .slip_cnt(slip_cnt2), .align_fail(align_fail2),
    .err_cnt(err_cnt2)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  // Drive one frame, push its data as the expected data_out, then compare
  // against the DUT one edge later.
  task automatic step(input logic [5:0] fw);
    logic [63:0] r;
    logic [47:0] exp;
    r = {$urandom(), $urandom()};
    rx_data = {fw, r[47:0]};
    sb_q.push_back(r[47:0]);
    @(posedge rx_clk);
    #1;
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      n_tests++;
      if (data_out !== exp) begin
        n_fail++;
        $display("FAIL data_out: got %h expected %h", data_out, exp);
      end
    end
  endtask

  task automatic do_reset();
    #2;
    reset_n   = 1'b0;
    rx_locked = 1'b0;
    rx_data   = '0;
    sb_q.delete();
    repeat (3) @(posedge rx_clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge rx_clk);
    #1;
  endtask

  task automatic run_to_lock(input int bound, output int cycles);
    cycles = -1;
    for (int i = 1; i <= bound; i++) begin
      step(PAT);
      if (align_locked) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx_locked = 1'b0;
    rx_data = '1;
    repeat (2) @(posedge rx_clk);
    #1;
    n_tests++;
    if ({rx_data_align, data_valid, align_locked, slip_cnt, align_fail, err_cnt, data_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero, expected all zero");
    end
    do_reset();
    n_tests++;
    if ({rx_data_align, data_valid, align_locked, slip_cnt, align_fail, err_cnt, data_out} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_outputs: got nonzero, expected all zero");
    end
  endtask

  task automatic test_lock_direct();
    bit saw_align = 0;
    logic lock16 = 1'b0;
    do_reset();
    rx_locked = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step(PAT);
      if (rx_data_align) saw_align = 1;
      if (i == 16) lock16 = align_locked;
    end
    n_tests++;
    if (lock16 !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_early: align_locked=%b at cycle 16, expected 0", lock16);
    end
    n_tests++;
    if (align_locked !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_cycle17: align_locked=%b, expected 1", align_locked);
    end
    step(PAT);
    if (rx_data_align) saw_align = 1;
    n_tests++;
    if (data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_valid: data_valid=%b, expected 1", data_valid);
    end
    n_tests++;
    if (slip_cnt !== 3'd0 || saw_align) begin
      n_fail++;
      $display("FAIL lock_noslip: slip_cnt=%0d saw_align=%0d, expected 0 and 0", slip_cnt, saw_align);
    end
  endtask

  task automatic test_slip_align();
    logic [5:0] word = 6'b100011;
    bit prev = 0, width_bad = 0, gap_bad = 0;
    int pulses = 0, width = 0, last_rise = 0, cyc = 0;
    do_reset();
    rx_locked = 1'b1;
    while (!align_locked && cyc < 100) begin
      step(word);
      cyc++;
      if (rx_data_align) begin
        if (!prev) begin
          pulses++;
          if (pulses > 1 && cyc - last_rise < 7) gap_bad = 1;
          last_rise = cyc;
          word = {word[0], word[5:1]};
          width = 1;
        end else begin
          width++;
        end
      end else if (prev && width != 2) begin
        width_bad = 1;
      end
      prev = rx_data_align;
    end
    n_tests++;
    if (align_locked !== 1'b1) begin
      n_fail++;
      $display("FAIL slip_lock: align_locked=%b after %0d cycles, expected 1", align_locked, cyc);
    end
    n_tests++;
    if (pulses != 2 || width_bad || gap_bad) begin
      n_fail++;
      $display("FAIL slip_pulses: pulses=%0d width_bad=%0d gap_bad=%0d, expected 2 0 0", pulses, width_bad, gap_bad);
    end
    n_tests++;
    if (slip_cnt !== 3'd2 || align_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL slip_cnt: slip_cnt=%0d align_fail=%b, expected 2 0", slip_cnt, align_fail);
    end
  endtask

  task automatic test_align_fail();
    bit prev = 0, saw_lock = 0;
    int pulses = 0, cyc = 0;
    do_reset();
    rx_locked = 1'b1;
    while (pulses < 7 && cyc < 80) begin
      step(6'b010101);
      cyc++;
      if (align_locked) saw_lock = 1;
      if (rx_data_align && !prev) begin
        pulses++;
        if (pulses == 5) begin
          n_tests++;
          if (slip_cnt !== 3'd5 || align_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL fail_5th: slip_cnt=%0d align_fail=%b, expected 5 0", slip_cnt, align_fail);
          end
        end else if (pulses == 6) begin
          n_tests++;
          if (slip_cnt !== 3'd0 || align_fail !== 1'b1) begin
            n_fail++;
            $display("FAIL fail_6th: slip_cnt=%0d align_fail=%b, expected 0 1", slip_cnt, align_fail);
          end
        end else if (pulses == 7) begin
          n_tests++;
          if (slip_cnt !== 3'd1 || align_fail !== 1'b1) begin
            n_fail++;
            $display("FAIL fail_retry: slip_cnt=%0d align_fail=%b, expected 1 1", slip_cnt, align_fail);
          end
        end
      end
      prev = rx_data_align;
    end
    n_tests++;
    if (pulses != 7 || saw_lock) begin
      n_fail++;
      $display("FAIL fail_pulses: pulses=%0d saw_lock=%0d, expected 7 0", pulses, saw_lock);
    end
  endtask

  task automatic test_loss();
    int c;
    do_reset();
    rx_locked = 1'b1;
    run_to_lock(40, c);
    n_tests++;
    if (c != 17) begin
      n_fail++;
      $display("FAIL loss_lock: lock cycle %0d, expected 17", c);
    end
    for (int k = 0; k < 3; k++) begin
      step(BAD);
      n_tests++;
      if (data_valid !== 1'b0 || align_locked !== 1'b1) begin
        n_fail++;
        $display("FAIL loss_isolated: data_valid=%b align_locked=%b, expected 0 1", data_valid, align_locked);
      end
      step(PAT);
      n_tests++;
      if (data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL loss_recover: data_valid=%b, expected 1", data_valid);
      end
    end
    for (int j = 0; j < 4; j++) begin
      step(BAD);
      n_tests++;
      if (data_valid !== 1'b0 || align_locked !== (j < 3)) begin
        n_fail++;
        $display("FAIL loss_consec%0d: data_valid=%b align_locked=%b, expected 0 %0d", j, data_valid, align_locked, j < 3);
      end
    end
    n_tests++;
    if (err_cnt !== 16'd7) begin
      n_fail++;
      $display("FAIL loss_err_cnt: err_cnt=%0d, expected 7", err_cnt);
    end
  endtask

  task automatic test_rx_locked_drop();
    int c;
    bit saw_align = 0;
    do_reset();
    rx_locked = 1'b1;
    run_to_lock(40, c);
    step(BAD);
    step(PAT);
    repeat (4) step(BAD);
    step(BAD);
    n_tests++;
    if (rx_data_align !== 1'b1 || slip_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL drop_in_slip: rx_data_align=%b slip_cnt=%0d, expected 1 1", rx_data_align, slip_cnt);
    end
    rx_locked = 1'b0;
    step(BAD);
    n_tests++;
    if (rx_data_align !== 1'b0 || align_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_align: rx_data_align=%b align_locked=%b, expected 0 0", rx_data_align, align_locked);
    end
    n_tests++;
    if (err_cnt !== 16'd5 || slip_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL drop_kept: err_cnt=%0d slip_cnt=%0d, expected 5 1", err_cnt, slip_cnt);
    end
    repeat (5) begin
      step(BAD);
      if (rx_data_align) saw_align = 1;
    end
    n_tests++;
    if (saw_align) begin
      n_fail++;
      $display("FAIL drop_idle: rx_data_align pulsed while rx_locked=0, expected none");
    end
    rx_locked = 1'b1;
    run_to_lock(40, c);
    n_tests++;
    if (c != 17 || err_cnt !== 16'd5 || slip_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL drop_relock: lock=%0d err_cnt=%0d slip_cnt=%0d, expected 17 5 0", c, err_cnt, slip_cnt);
    end
  endtask

  task automatic test_err_saturate();
    do_reset();
    rx_locked = 1'b1;
    repeat (17) step(PAT);
    n_tests++;
    if (align_locked2 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_lock: align_locked=%b, expected 1", align_locked2);
    end
    for (int i = 1; i <= 65540; i++) begin
      step(BAD);
      if (i == 65534) begin
        n_tests++;
        if (err_cnt2 !== 16'hFFFE) begin
          n_fail++;
          $display("FAIL sat_fffe: err_cnt=%h, expected fffe", err_cnt2);
        end
      end else if (i == 65535) begin
        n_tests++;
        if (err_cnt2 !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL sat_ffff: err_cnt=%h, expected ffff", err_cnt2);
        end
      end
    end
    n_tests++;
    if (err_cnt2 !== 16'hFFFF || align_locked2 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_hold: err_cnt=%h align_locked=%b, expected ffff 1", err_cnt2, align_locked2);
    end
  endtask

  task automatic test_async_reset();
    int c;
    do_reset();
    rx_locked = 1'b1;
    run_to_lock(40, c);
    step(BAD);
    step(PAT);
    n_tests++;
    if (align_locked !== 1'b1 || err_cnt !== 16'd1 || data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: align_locked=%b err_cnt=%0d data_valid=%b, expected 1 1 1", align_locked, err_cnt, data_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({rx_data_align, data_valid, align_locked, slip_cnt, align_fail, err_cnt, data_out} !== '0) begin
      n_fail++;
      $display("FAIL areset_immediate: outputs nonzero before next edge, expected all zero");
    end
    do_reset();
  endtask

  initial begin
    reset_n   = 1'b0;
    rx_locked = 1'b0;
    rx_data   = '0;
    test_reset();
    test_lock_direct();
    test_slip_align();
    test_align_fail();
    test_loss();
    test_rx_locked_drop();
    test_err_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
